resource_port: RTL and testbench
================================

# resource_port

Downstream stage of the three-client token-ring arbitration. It consumes the per-client `ack` grants from the controllers and routes the owning client's write stream onto a single shared output channel with a valid/ready handshake. It also checks grant exclusivity and ownership duration, and counts grants per client. It is the only path from the clients to the shared resource.

## Interface
- `DW`, 8: data width per client and on the shared channel.
- `CW`, 8: width of each per-client grant counter.
- `HOLD_MAX`, 15: ownership length in cycles at which the overrun flag sets.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `ack`  in  3  grants from the controllers; bit0=A, bit1=B, bit2=C.
- `wr_valid`  in  3  per-client write valid; same bit order as `ack`.
- `wr_data_a` / `wr_data_b` / `wr_data_c`  in  DW each  per-client write data.
- `wr_ready`  out  3  per-client write ready.
- `out_valid`  out  1  shared channel valid.
- `out_data`  out  DW  shared channel data.
- `out_owner`  out  2  client that produced `out_data`; 0=A, 1=B, 2=C.
- `out_ready`  in  1  shared channel ready.
- `busy`  out  1  high when the FSM is not in IDLE.
- `conflict`  out  1  sticky; a grant-exclusivity violation occurred.
- `overrun`  out  1  sticky; an ownership lasted HOLD_MAX cycles.
- `grant_cnt_a` / `grant_cnt_b` / `grant_cnt_c`  out  CW each  saturating grant counters.

## Operation
- FSM states: IDLE, OWN, DRAIN, ERR. All state is registered.
- Reset (`rst`=0) asynchronously clears everything:
  - state=IDLE, owner=3, `out_valid`=0, `out_data`=0, `wr_ready`=000.
  - `conflict`=0, `overrun`=0, hold counter=0, all grant counters=0.
- IDLE:
  - Exactly one `ack` bit high: go to OWN, latch owner=bit index, increment that client's grant counter (saturates at 2^CW-1), clear hold counter.
  - More than one `ack` bit high: go to ERR, set `conflict`.
  - No `ack` bit high: stay in IDLE.
- OWN:
  - `wr_ready[owner]` = !`out_valid` || `out_ready`. All other `wr_ready` bits are 0.
  - Write accept: when `wr_valid[owner]` && `wr_ready[owner]`, on the next edge `out_data`=`wr_data_<owner>`, `out_owner`=owner, `out_valid`=1.
  - When `out_valid` && `out_ready` and no accept happens in the same cycle, `out_valid` goes to 0.
  - Hold counter increments each OWN cycle and saturates. When it reaches HOLD_MAX, `overrun` is set. The state does not change.
  - Any non-owner `ack` bit high: go to ERR, set `conflict`. This check takes priority over the drop check below.
  - `ack[owner]` drops: go to IDLE if `out_valid` is 0 or is being accepted this cycle; otherwise go to DRAIN.
- DRAIN:
  - `wr_ready`=000.
  - Stay until `out_valid` && `out_ready`, then go to IDLE.
  - Any `ack` bit high in DRAIN: go to ERR, set `conflict`.
- ERR:
  - Terminal until reset.
  - `wr_ready`=000.
  - A pending `out_valid` still drains normally. No new data is accepted.
- `out_data` and `out_owner` stay stable while `out_valid`=1 and `out_ready`=0.
- `busy` = (state != IDLE).

## Timing
- Grant to ready: `ack` is sampled high at edge t; `wr_ready[owner]` is high during cycle t+1 at the earliest.
- Write to output: a write accepted at edge t gives `out_valid`=1 with that data after edge t.
- Back-to-back: with `out_ready` held at 1, one word is accepted per cycle.
- Release: the cycle after the last word is accepted with `ack` low, the FSM is in IDLE. A new grant sampled at that edge is taken on the following edge. This gives a one-cycle minimum IDLE gap.
- Sticky flags set on the edge where the condition is sampled and stay set until reset.

## Test plan
- Reset: drive `rst`=0 mid-OWN with `out_valid`=1. All outputs go to reset values immediately, without waiting for a clock edge. Release `rst`; state is IDLE and all counters are 0.
- Single grant burst: `ack`=001, client A sends 4 words 0x11..0x14 with `out_ready`=1. The channel shows 0x11..0x14 on consecutive cycles with `out_owner`=0. `grant_cnt_a`=1.
- Backpressure and drain: client B owns with `out_ready`=0; B writes 0x5A, then `ack` drops. State goes to DRAIN and `out_data` holds 0x5A. Raise `out_ready`; one transfer completes and the FSM returns to IDLE.
- Conflict: `ack`=011 in IDLE, or `ack`=100 then 110 in OWN. `conflict`=1, state is ERR, `wr_ready`=000 from then on, and the flag persists after `ack`=000.
- Overrun: client C holds `ack` for 20 cycles with HOLD_MAX=15. `overrun` rises after the 15th OWN cycle and data flow is unaffected.
- Rotation and saturation: with CW=2, cycle grants A, B, C five times each. Each counter reads 3 (saturated) and every `out_owner` value matches the granting client.

Source files
------------

// File: rtl/resource_port.sv
// rtl/resource_port.sv - routes the granted client's write stream onto one shared channel
module resource_port #(
  parameter int DW       = 8,
  parameter int CW       = 8,
  parameter int HOLD_MAX = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    ack,
  input  logic [2:0]    wr_valid,
  input  logic [DW-1:0] wr_data_a,
  input  logic [DW-1:0] wr_data_b,
  input  logic [DW-1:0] wr_data_c,
  output logic [2:0]    wr_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_owner,
  input  logic          out_ready,
  output logic          busy,
  output logic          conflict,
  output logic          overrun,
  output logic [CW-1:0] grant_cnt_a,
  output logic [CW-1:0] grant_cnt_b,
  output logic [CW-1:0] grant_cnt_c
);

  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_MAX);

  typedef enum logic [1:0] {IDLE, OWN, DRAIN, ERR} state_t;

  state_t        state, state_nxt;
  logic [1:0]    owner, owner_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [2:0]    owner_mask;
  logic [1:0]    ack_idx;
  logic          ack_single;
  logic          ack_multi;
  logic          own_ready;
  logic          accept;
  logic          drain;
  logic [DW-1:0] sel_data;
  logic          set_conflict;
  logic [2:0]    grant_inc;
  logic          hold_clr;

  // Decode owner into a one-hot mask, pick its write data and classify the grant vector
  always_comb begin
    owner_mask = 3'b000;
    sel_data   = '0;
    case (owner)
      2'd0: begin owner_mask = 3'b001; sel_data = wr_data_a; end
      2'd1: begin owner_mask = 3'b010; sel_data = wr_data_b; end
      2'd2: begin owner_mask = 3'b100; sel_data = wr_data_c; end
      default: begin owner_mask = 3'b000; sel_data = '0; end
    endcase
    ack_single = 1'b0;
    ack_idx    = 2'd0;
    case (ack)
      3'b001: begin ack_single = 1'b1; ack_idx = 2'd0; end
      3'b010: begin ack_single = 1'b1; ack_idx = 2'd1; end
      3'b100: begin ack_single = 1'b1; ack_idx = 2'd2; end
      default: begin ack_single = 1'b0; ack_idx = 2'd0; end
    endcase
    ack_multi = (ack != 3'b000) && !ack_single;
  end

  assign own_ready = !out_valid || out_ready;
  assign drain     = out_valid && out_ready;
  assign accept    = (state == OWN) && ((wr_valid & owner_mask) != 3'b000) && own_ready;
  assign hold_nxt  = (hold_cnt == HMAX) ? hold_cnt : hold_cnt + HW'(1);
  assign busy      = (state != IDLE);

  // Next-state, ready generation and event strobes for the ownership FSM
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    set_conflict = 1'b0;
    grant_inc    = 3'b000;
    hold_clr     = 1'b0;
    wr_ready     = 3'b000;
    case (state)
      IDLE: begin
        if (ack_single) begin
          state_nxt = OWN;
          owner_nxt = ack_idx;
          grant_inc = ack;
          hold_clr  = 1'b1;
        end else if (ack_multi) begin
          state_nxt    = ERR;
          set_conflict = 1'b1;
        end
      end
      OWN: begin
        wr_ready = owner_mask & {3{own_ready}};
        // A foreign grant is a hard error even if the owner is releasing at the same time
        if ((ack & ~owner_mask) != 3'b000) begin
          state_nxt    = ERR;
          set_conflict = 1'b1;
        end else if ((ack & owner_mask) == 3'b000) begin
          state_nxt = (!out_valid || drain) ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        if (ack != 3'b000) begin
          state_nxt    = ERR;
          set_conflict = 1'b1;
        end else if (drain) begin
          state_nxt = IDLE;
        end
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state and current owner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= 2'd3;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // Shared output channel register; holds steady under backpressure
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_owner <= 2'd0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_owner <= owner;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  // Ownership hold counter and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt <= '0;
      conflict <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (hold_clr) begin
        hold_cnt <= '0;
      end else if (state == OWN) begin
        hold_cnt <= hold_nxt;
      end
      if (set_conflict) begin
        conflict <= 1'b1;
      end
      if ((state == OWN) && (hold_nxt == HMAX)) begin
        overrun <= 1'b1;
      end
    end
  end

  // Saturating per-client grant counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt_a <= '0;
      grant_cnt_b <= '0;
      grant_cnt_c <= '0;
    end else begin
      if (grant_inc[0] && (grant_cnt_a != {CW{1'b1}})) grant_cnt_a <= grant_cnt_a + CW'(1);
      if (grant_inc[1] && (grant_cnt_b != {CW{1'b1}})) grant_cnt_b <= grant_cnt_b + CW'(1);
      if (grant_inc[2] && (grant_cnt_c != {CW{1'b1}})) grant_cnt_c <= grant_cnt_c + CW'(1);
    end
  end

endmodule

// File: tb/tb_resource_port.sv
// tb/tb_resource_port.sv - directed self-checking bench for resource_port
module tb_resource_port;

  logic       clk;
  logic       rst;
  logic [2:0] ack;
  logic [2:0] wr_valid;
  logic [7:0] wr_data_a, wr_data_b, wr_data_c;
  logic [2:0] wr_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_owner;
  logic       out_ready;
  logic       busy, conflict, overrun;
  logic [1:0] grant_cnt_a, grant_cnt_b, grant_cnt_c;

  int checks   = 0;
  int failures = 0;

  resource_port #(.DW(8), .CW(2), .HOLD_MAX(15)) dut (
    .clk(clk), .rst(rst), .ack(ack), .wr_valid(wr_valid),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b), .wr_data_c(wr_data_c),
    .wr_ready(wr_ready), .out_valid(out_valid), .out_data(out_data),
    .out_owner(out_owner), .out_ready(out_ready), .busy(busy),
    .conflict(conflict), .overrun(overrun),
    .grant_cnt_a(grant_cnt_a), .grant_cnt_b(grant_cnt_b), .grant_cnt_c(grant_cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int c, input logic [7:0] d);
    case (c)
      0: wr_data_a = d;
      1: wr_data_b = d;
      default: wr_data_c = d;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ack = 3'b000;
    wr_valid = 3'b000;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b0; ack = 3'b000; wr_valid = 3'b000; out_ready = 1'b0;
    wr_data_a = 8'h00; wr_data_b = 8'h00; wr_data_c = 8'h00;
    tick(); tick();
    rst = 1'b1;
    tick();

    // reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {conflict, overrun}, 0);
    chk("rst_cnts", {grant_cnt_a, grant_cnt_b, grant_cnt_c}, 0);

    // single grant burst from A
    ack = 3'b001; out_ready = 1'b1;
    tick();
    chk("burst_busy", busy, 1);
    chk("burst_cnt_a", grant_cnt_a, 1);
    chk("burst_wr_ready", wr_ready, 3'b001);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 3'b001;
      wr_data_a = 8'h11 + 8'(i);
      tick();
      chk("burst_valid", out_valid, 1);
      chk("burst_data", out_data, 32'h11 + i);
      chk("burst_owner", out_owner, 0);
    end
    ack = 3'b000; wr_valid = 3'b000;
    tick();
    chk("burst_release_busy", busy, 0);
    chk("burst_release_valid", out_valid, 0);
    chk("burst_cnt_a_end", grant_cnt_a, 1);

    // backpressure and drain with B
    ack = 3'b010; out_ready = 1'b0;
    tick();
    chk("bp_cnt_b", grant_cnt_b, 1);
    chk("bp_wr_ready", wr_ready, 3'b010);
    wr_valid = 3'b010; wr_data_b = 8'h5A;
    tick();
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 8'h5A);
    chk("bp_owner", out_owner, 1);
    wr_valid = 3'b000; ack = 3'b000;
    #1;
    chk("bp_ready_stalled", wr_ready, 3'b000);
    tick();
    chk("drain_busy", busy, 1);
    chk("drain_data", out_data, 8'h5A);
    tick();
    chk("drain_hold_valid", out_valid, 1);
    chk("drain_hold_data", out_data, 8'h5A);
    out_ready = 1'b1;
    #1;
    chk("drain_wr_ready", wr_ready, 3'b000);
    tick();
    chk("drain_done_busy", busy, 0);
    chk("drain_done_valid", out_valid, 0);
    chk("drain_no_conflict", conflict, 0);

    // conflict inside OWN
    ack = 3'b100;
    tick();
    chk("own_c_busy", busy, 1);
    ack = 3'b110;
    tick();
    chk("own_conflict", conflict, 1);
    ack = 3'b000; wr_valid = 3'b100; wr_data_c = 8'hEE;
    tick();
    chk("err_persist", conflict, 1);
    chk("err_busy", busy, 1);
    chk("err_wr_ready", wr_ready, 3'b000);
    tick();
    chk("err_no_accept", out_valid, 0);
    wr_valid = 3'b000;

    // conflict in IDLE
    do_reset();
    chk("reset_clears_conflict", conflict, 0);
    ack = 3'b011;
    tick();
    chk("idle_conflict", conflict, 1);
    chk("idle_conflict_busy", busy, 1);
    ack = 3'b000;
    tick();
    chk("idle_conflict_persist", conflict, 1);
    chk("idle_conflict_wr_ready", wr_ready, 3'b000);

    // asynchronous reset mid-OWN with pending output
    do_reset();
    ack = 3'b001; out_ready = 1'b0;
    tick();
    wr_valid = 3'b001; wr_data_a = 8'h77;
    tick();
    chk("pre_areset_valid", out_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("areset_valid", out_valid, 0);
    chk("areset_data", out_data, 0);
    chk("areset_wr_ready", wr_ready, 0);
    chk("areset_busy", busy, 0);
    chk("areset_cnt_a", grant_cnt_a, 0);
    ack = 3'b000; wr_valid = 3'b000;
    tick();
    rst = 1'b1;
    tick();
    chk("post_areset_busy", busy, 0);
    chk("post_areset_cnts", {grant_cnt_a, grant_cnt_b, grant_cnt_c}, 0);

    // overrun: C holds ownership for 20 cycles while streaming
    ack = 3'b100; out_ready = 1'b1;
    tick();
    for (int i = 1; i <= 20; i++) begin
      wr_valid = 3'b100;
      wr_data_c = 8'h20 + 8'(i);
      tick();
      chk("ovr_flag", overrun, (i >= 15) ? 1 : 0);
      chk("ovr_data", out_data, 32'h20 + i);
      chk("ovr_valid", out_valid, 1);
    end
    ack = 3'b000; wr_valid = 3'b000;
    tick();
    chk("ovr_persist", overrun, 1);
    chk("ovr_release_busy", busy, 0);
    chk("ovr_owner", out_owner, 2);

    // rotation and saturation with CW=2
    do_reset();
    out_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 3; c++) begin
        ack = 3'b001 << c;
        tick();
        wr_valid = 3'b001 << c;
        set_data(c, 8'(r * 16 + c));
        tick();
        chk("rot_owner", out_owner, c);
        chk("rot_data", out_data, r * 16 + c);
        case (c)
          0: chk("rot_cnt_a", grant_cnt_a, (r + 1 > 3) ? 3 : r + 1);
          1: chk("rot_cnt_b", grant_cnt_b, (r + 1 > 3) ? 3 : r + 1);
          default: chk("rot_cnt_c", grant_cnt_c, (r + 1 > 3) ? 3 : r + 1);
        endcase
        ack = 3'b000; wr_valid = 3'b000;
        tick();
      end
    end
    chk("sat_cnt_a", grant_cnt_a, 3);
    chk("sat_cnt_b", grant_cnt_b, 3);
    chk("sat_cnt_c", grant_cnt_c, 3);
    chk("sat_no_flags", {conflict, overrun}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
